// File: rtl/sram_frame_reader_if.sv
// Bus bundle between the frame reader, the external SRAM and the VGA DAC.
//   i_enable        : scan enable from system control
//   o_sram_addr     : SRAM word address (0 outside the visible area)
//   i_sram_dq       : SRAM read data
//   o_sram_oe_n     : SRAM output enable, active low
//   o_sram_we_n     : SRAM write enable, always inactive
//   o_bus_busy      : reader owns the SRAM bus this cycle
//   o_vga_r/g/b     : 8-bit pixel colour
//   o_vga_hs/vs     : syncs, active low
//   o_vga_blank_n   : 0 outside the visible area
//   o_vga_clk       : 25 MHz pixel clock to the DAC
//   o_frame_start   : one-clock pulse at the start of each frame
// master = the frame reader, slave = SRAM / DAC / control side.
interface sram_frame_reader_if;
   logic        i_enable;
   logic [19:0] o_sram_addr;
   logic [15:0] i_sram_dq;
   logic        o_sram_oe_n;
   logic        o_sram_we_n;
   logic        o_bus_busy;
   logic [7:0]  o_vga_r;
   logic [7:0]  o_vga_g;
   logic [7:0]  o_vga_b;
   logic        o_vga_hs;
   logic        o_vga_vs;
   logic        o_vga_blank_n;
   logic        o_vga_clk;
   logic        o_frame_start;

   modport master (
      input  i_enable, i_sram_dq,
      output o_sram_addr, o_sram_oe_n, o_sram_we_n, o_bus_busy,
             o_vga_r, o_vga_g, o_vga_b, o_vga_hs, o_vga_vs,
             o_vga_blank_n, o_vga_clk, o_frame_start
   );

   modport slave (
      output i_enable, i_sram_dq,
      input  o_sram_addr, o_sram_oe_n, o_sram_we_n, o_bus_busy,
             o_vga_r, o_vga_g, o_vga_b, o_vga_hs, o_vga_vs,
             o_vga_blank_n, o_vga_clk, o_frame_start
   );
endinterface

// File: rtl/sram_frame_reader.sv
// Reader end of the camera frame buffer in external SRAM.
// Generates VGA timing (2 system clocks per pixel), reads one 16-bit
// {R4,G4,B4,4'b0} word per visible pixel and drives the DAC with the
// colour expanded to 8 bits per channel. Colour, syncs and blank_n are
// registered together, one pixel (2 clocks) after the address is shown.
// Ports:
//   i_clk   : system clock (50 MHz)
//   i_rst_n : asynchronous active-low reset
//   bus     : SRAM / VGA / enable bundle (master side)
module sram_frame_reader #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter logic [19:0] BASE_ADDR = 20'd0
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   sram_frame_reader_if.master  bus
);

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW       = $clog2(H_TOTAL);
   localparam int unsigned VW       = $clog2(V_TOTAL);
   localparam int unsigned AW       = 20;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic            frame_start_d;
   logic            frame_start_q;

   logic            ph_q;
   logic [HW-1:0]   h_cnt_q;
   logic [VW-1:0]   v_cnt_q;
   logic [AW-1:0]   addr_cnt_q;
   logic [7:0]      r_q;
   logic [7:0]      g_q;
   logic [7:0]      b_q;
   logic            hs_q;
   logic            vs_q;
   logic            blank_n_q;

   logic            run_c;
   logic            vis_c;
   logic            read_c;
   logic            tick_c;
   logic            h_last_c;
   logic            v_last_c;
   logic            hs_on_c;
   logic            vs_on_c;

   // Scan position decode
   assign run_c    = (state_q == ST_RUN);
   assign vis_c    = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
   assign read_c   = run_c && vis_c;
   assign tick_c   = run_c && ph_q;
   assign h_last_c = (h_cnt_q == HW'(H_TOTAL - 1));
   assign v_last_c = (v_cnt_q == VW'(V_TOTAL - 1));
   assign hs_on_c  = (h_cnt_q >= HW'(HS_START)) && (h_cnt_q < HW'(HS_END));
   assign vs_on_c  = (v_cnt_q >= VW'(VS_START)) && (v_cnt_q < VW'(VS_END));

   // Run/idle state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= ST_IDLE;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         frame_start_q <= frame_start_d;
      end
   end

   // Next state; frame pulse on leaving idle or on the last tick of a frame
   always_comb begin
      state_d       = state_q;
      frame_start_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.i_enable) begin
               state_d       = ST_RUN;
               frame_start_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (!bus.i_enable) begin
               state_d = ST_IDLE;
            end else if (tick_c && h_last_c && v_last_c) begin
               frame_start_d = 1'b1;
            end
         end
      endcase
   end

   // Pixel phase, scan counters, address counter and registered DAC outputs.
   // While idle (or on the edge that enters idle) everything is held clear so
   // that scanning restarts at (0,0) with ph=0.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ph_q       <= 1'b0;
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         addr_cnt_q <= '0;
         r_q        <= '0;
         g_q        <= '0;
         b_q        <= '0;
         hs_q       <= 1'b1;
         vs_q       <= 1'b1;
         blank_n_q  <= 1'b0;
      end else if (!bus.i_enable || !run_c) begin
         ph_q       <= 1'b0;
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         addr_cnt_q <= '0;
         r_q        <= '0;
         g_q        <= '0;
         b_q        <= '0;
         hs_q       <= 1'b1;
         vs_q       <= 1'b1;
         blank_n_q  <= 1'b0;
      end else begin
         ph_q <= ~ph_q;
         if (ph_q) begin
            // End of the pixel: latch the settled SRAM word with its syncs
            if (vis_c) begin
               r_q <= {bus.i_sram_dq[15:12], bus.i_sram_dq[15:12]};
               g_q <= {bus.i_sram_dq[11:8],  bus.i_sram_dq[11:8]};
               b_q <= {bus.i_sram_dq[7:4],   bus.i_sram_dq[7:4]};
            end else begin
               r_q <= '0;
               g_q <= '0;
               b_q <= '0;
            end
            hs_q      <= ~hs_on_c;
            vs_q      <= ~vs_on_c;
            blank_n_q <= vis_c;

            if (h_last_c) begin
               h_cnt_q <= '0;
               v_cnt_q <= v_last_c ? '0 : v_cnt_q + VW'(1);
            end else begin
               h_cnt_q <= h_cnt_q + HW'(1);
            end

            // Running address avoids a row*width multiplier
            if (h_last_c && v_last_c) begin
               addr_cnt_q <= '0;
            end else if (vis_c) begin
               addr_cnt_q <= addr_cnt_q + AW'(1);
            end
         end
      end
   end

   // SRAM side: address and OE follow the current pixel directly
   assign bus.o_sram_addr   = read_c ? (BASE_ADDR + addr_cnt_q) : '0;
   assign bus.o_sram_oe_n   = ~read_c;
   assign bus.o_sram_we_n   = 1'b1;
   assign bus.o_bus_busy    = read_c;

   // DAC side: pixel clock rises in the middle of each output pixel
   assign bus.o_vga_r       = r_q;
   assign bus.o_vga_g       = g_q;
   assign bus.o_vga_b       = b_q;
   assign bus.o_vga_hs      = hs_q;
   assign bus.o_vga_vs      = vs_q;
   assign bus.o_vga_blank_n = blank_n_q;
   assign bus.o_vga_clk     = ph_q;
   assign bus.o_frame_start = frame_start_q;

endmodule

// File: tb/tb_sram_frame_reader.sv
// Bench for sram_frame_reader on a reduced raster (30x13 pixels, 16x6
// visible) with a non-zero base address, so whole frames fit in a short run.
module tb_sram_frame_reader;

   localparam int HA = 16, HF = 4, HS = 6, HB = 4;
   localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME_CLKS = 2 * HT * VT;
   localparam logic [19:0] BASE = 20'h10000;

   typedef struct packed {
      logic [19:0] addr;
      logic        oe_n;
      logic        we_n;
      logic        busy;
      logic [7:0]  r;
      logic [7:0]  g;
      logic [7:0]  b;
      logic        hs;
      logic        vs;
      logic        blank_n;
      logic        vclk;
      logic        fs;
   } obs_t;

   typedef struct {
      int          t;
      logic [19:0] addr;
      logic        oe_n;
      logic        blank_n;
      logic        hs;
      logic        vs;
      logic        fs;
      logic        chk_rgb;
      logic [23:0] rgb;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   t = -1;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [15:0] mem [0:127];
   vec_t vecs [0:19];

   always #10 clk = ~clk;

   sram_frame_reader_if bus ();

   sram_frame_reader #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .BASE_ADDR(BASE)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   // SRAM model: 128 words starting at BASE, zero elsewhere
   always_comb begin
      bus.i_sram_dq = 16'h0000;
      if (bus.o_sram_addr >= BASE && bus.o_sram_addr < BASE + 20'd128)
         bus.i_sram_dq = mem[7'(bus.o_sram_addr - BASE)];
   end

   function automatic obs_t sample();
      obs_t a;
      a.addr = bus.o_sram_addr;   a.oe_n = bus.o_sram_oe_n;
      a.we_n = bus.o_sram_we_n;   a.busy = bus.o_bus_busy;
      a.r = bus.o_vga_r;          a.g = bus.o_vga_g;   a.b = bus.o_vga_b;
      a.hs = bus.o_vga_hs;        a.vs = bus.o_vga_vs;
      a.blank_n = bus.o_vga_blank_n;
      a.vclk = bus.o_vga_clk;     a.fs = bus.o_frame_start;
      return a;
   endfunction

   // Reference: tt = clocks since scanning (re)started, -1 when idle/reset.
   // Pixel index = tt/2; outputs show the previous pixel.
   function automatic obs_t model(input int tt);
      obs_t e;
      int p, h, v, q;
      logic [15:0] w;
      e = '0;
      e.oe_n = 1'b1; e.we_n = 1'b1; e.hs = 1'b1; e.vs = 1'b1;
      if (tt >= 0) begin
         p = tt / 2;
         h = p % HT;
         v = (p / HT) % VT;
         e.vclk = ((tt % 2) == 1);
         e.fs   = ((tt % FRAME_CLKS) == 0);
         if (h < HA && v < VA) begin
            e.addr = BASE + 20'(v * HA + h);
            e.oe_n = 1'b0;
            e.busy = 1'b1;
         end
         if (tt >= 2) begin
            q = p - 1;
            h = q % HT;
            v = (q / HT) % VT;
            e.hs = !(h >= HA + HF && h < HA + HF + HS);
            e.vs = !(v >= VA + VF && v < VA + VF + VS);
            if (h < HA && v < VA) begin
               w = mem[v * HA + h];
               e.r = {w[15:12], w[15:12]};
               e.g = {w[11:8],  w[11:8]};
               e.b = {w[7:4],   w[7:4]};
               e.blank_n = 1'b1;
            end
         end
      end
      return e;
   endfunction

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (t=%0d): got %h expected %h", name, t, act, exp);
      end
   endtask

   task automatic check_model();
      cmp("cycle", 64'(sample()), 64'(model(t)));
   endtask

   // One clock: update the reference on the edge, compare on the low phase
   task automatic step();
      @(posedge clk);
      if (!rst_n || !bus.i_enable) t = -1;
      else t = t + 1;
      @(negedge clk);
      check_model();
   endtask

   task automatic run_to(input int target);
      int guard;
      guard = 0;
      while (t < target && guard < 5000) begin
         step();
         guard++;
      end
      if (t != target) cmp("run_to_timeout", 64'(t), 64'(target));
   endtask

   initial begin
      obs_t a;
      for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
      mem[0] = 16'hF5A0;
      bus.i_enable = 1'b0;

      //            t    addr        oe blk hs vs fs chk rgb
      vecs[0]  = '{  0, 20'h10000,   0, 0, 1, 1, 1, 0, 24'h0};
      vecs[1]  = '{  1, 20'h10000,   0, 0, 1, 1, 0, 0, 24'h0};
      vecs[2]  = '{  2, 20'h10001,   0, 1, 1, 1, 0, 1, 24'hFF55AA};
      vecs[3]  = '{ 31, 20'h1000F,   0, 1, 1, 1, 0, 0, 24'h0};
      vecs[4]  = '{ 32, 20'h00000,   1, 1, 1, 1, 0, 0, 24'h0};
      vecs[5]  = '{ 34, 20'h00000,   1, 0, 1, 1, 0, 1, 24'h0};
      vecs[6]  = '{ 41, 20'h00000,   1, 0, 1, 1, 0, 0, 24'h0};
      vecs[7]  = '{ 42, 20'h00000,   1, 0, 0, 1, 0, 0, 24'h0};
      vecs[8]  = '{ 53, 20'h00000,   1, 0, 0, 1, 0, 0, 24'h0};
      vecs[9]  = '{ 54, 20'h00000,   1, 0, 1, 1, 0, 0, 24'h0};
      vecs[10] = '{ 60, 20'h10010,   0, 0, 1, 1, 0, 0, 24'h0};
      vecs[11] = '{330, 20'h1005F,   0, 1, 1, 1, 0, 0, 24'h0};
      vecs[12] = '{481, 20'h00000,   1, 0, 1, 1, 0, 0, 24'h0};
      vecs[13] = '{482, 20'h00000,   1, 0, 1, 0, 0, 0, 24'h0};
      vecs[14] = '{601, 20'h00000,   1, 0, 1, 0, 0, 0, 24'h0};
      vecs[15] = '{602, 20'h00000,   1, 0, 1, 1, 0, 0, 24'h0};
      vecs[16] = '{779, 20'h00000,   1, 0, 1, 1, 0, 0, 24'h0};
      vecs[17] = '{780, 20'h10000,   0, 0, 1, 1, 1, 0, 24'h0};
      vecs[18] = '{781, 20'h10000,   0, 0, 1, 1, 0, 0, 24'h0};
      vecs[19] = '{782, 20'h10001,   0, 1, 1, 1, 0, 1, 24'hFF55AA};

      // Reset state
      repeat (3) @(negedge clk);
      check_model();
      rst_n = 1'b1;
      step();
      step();

      // Directed raster points from a fresh enable
      bus.i_enable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         run_to(vecs[i].t);
         a = sample();
         cmp($sformatf("vec%0d_timing", i),
             64'({a.addr, a.oe_n, a.blank_n, a.hs, a.vs, a.fs}),
             64'({vecs[i].addr, vecs[i].oe_n, vecs[i].blank_n,
                  vecs[i].hs, vecs[i].vs, vecs[i].fs}));
         if (vecs[i].chk_rgb)
            cmp($sformatf("vec%0d_rgb", i), 64'({a.r, a.g, a.b}), 64'(vecs[i].rgb));
      end

      // Drop enable at pixel (10,3) of the second frame
      run_to(FRAME_CLKS + 200);
      a = sample();
      cmp("pre_drop_visible", 64'({a.oe_n, a.blank_n}), 64'(2'b01));
      bus.i_enable = 1'b0;
      step();
      a = sample();
      cmp("drop_idle", 64'({a.oe_n, a.busy, a.blank_n, a.hs, a.vs}), 64'(5'b10011));
      step();
      step();
      bus.i_enable = 1'b1;
      step();
      a = sample();
      cmp("reenable_start", 64'({a.fs, a.addr, a.oe_n}), 64'({1'b1, BASE, 1'b0}));

      // Asynchronous reset mid-frame, between clock edges
      run_to(150);
      #3 rst_n = 1'b0;
      #1;
      a = sample();
      cmp("async_reset", 64'(a), 64'(model(-1)));
      t = -1;
      @(negedge clk);
      check_model();
      rst_n = 1'b1;
      step();
      a = sample();
      cmp("post_reset_start", 64'({a.fs, a.addr}), 64'({1'b1, BASE}));

      // Random enable drops against the reference
      for (int i = 0; i < 6000; i++) begin
         if (bus.i_enable) bus.i_enable = ($urandom_range(0, 999) != 0);
         else              bus.i_enable = ($urandom_range(0, 3) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
